gas_level_serializer: RTL and testbench
=======================================

// Module: gas_level_serializer
// PURPOSE
//  Transmit end of the gas-sensor serial link: takes a 3-bit gas-level code and
//  drives it onto the one-wire line 'dout' as a framed bit stream for the gas
//  detector receiver. Sits between the sensor front-end (level source) and the link.
//  A one-entry hold register lets the source queue the next code during a frame.
// PARAMETERS
//  BIT_CYCLES  1  clock cycles per transmitted bit (>=1)
//  PARITY_EN   1  1: odd-parity bit after data; 0: parity bit omitted
// PORTS
//  clk         in   1  rising-edge clock, the only clock
//  arst        in   1  asynchronous reset, ACTIVE-LOW (0 = reset)
//  level       in   3  gas-level code to send
//  level_valid in   1  source offers 'level' this cycle
//  level_ready out  1  block accepts 'level' this cycle (= !hold_full; 0 during reset)
//  dout        out  1  serial line, registered; idles at 0
//  busy        out  1  1 while a frame is on the line (state != IDLE)
//  frame_done  out  1  one-cycle pulse in the last clock of each STOP bit
// BEHAVIOUR
//  - Reset (arst=0, async): state=IDLE, dout=0, busy=0, frame_done=0, hold empty,
//    shifter/counters cleared; level_ready=0 while arst=0, 1 after release.
//  - Handshake: transfer when level_valid&&level_ready at a rising edge. level is
//    sampled only then; level_valid with level_ready=0 is ignored (source holds).
//  - Frame: START(1) D2 D1 D0 (MSB first) [PARITY=~^level] STOP(0). Each bit held
//    exactly BIT_CYCLES clocks. Frame = 6*BIT_CYCLES clocks (5* if PARITY_EN=0).
//  - FSM IDLE->START->DATA(x3, idx 2..0)->PARITY->STOP->IDLE or START.
//    PARITY skipped when PARITY_EN=0 (DATA->STOP).
//    Bit counter counts 0..BIT_CYCLES-1; state/bit advances when counter wraps.
//  - Latency: transfer at edge N while IDLE with hold empty -> shifter loads
//    directly, dout=1 (START) from edge N, busy=1 from edge N.
//  - Transfer while busy -> word goes to hold register, level_ready=0 next cycle.
//  - End of STOP: if hold full -> load shifter from hold, go START on the next edge.
//    No idle gap; hold empties; level_ready=1. Else -> IDLE, dout=0, busy=0.
//  - Simultaneous: transfer in same cycle as STOP end with hold empty -> word
//    loads straight into shifter (back-to-back); hold stays empty.
//  - Hold full + level_valid: ready=0, no overwrite; the held word is never lost.
//  - Reset mid-frame: frame aborted immediately, dout=0, hold discarded; no pulse.
//  - frame_done asserts in the last clock of STOP only; never for aborted frames.
// TESTING
//  1 BIT_CYCLES=1, send 3'b101 from IDLE -> dout 1,1,0,1,1,0 over 6 clks;
//    frame_done on 6th clk; busy=0 after.
//  2 send 3'b111 -> dout 1,1,1,1,0,0 (parity 0); send 3'b000 -> 1,0,0,0,1,0.
//  3 send 3'b010 then 3'b110 on next clk -> ready=0 after 2nd transfer; frames
//    contiguous 1,0,1,0,0,0 | 1,1,1,0,1,0 with no idle clock.
//  4 BIT_CYCLES=4, 3'b001 -> each bit held 4 clks, 24-clk frame, 1 frame_done.
//  5 arst=0 during D1 of 3'b011 with hold loaded -> dout=0 at once; busy=0;
//    after release line stays 0, no frame_done until new transfer.
//  6 PARITY_EN=0, 3'b100 -> dout 1,1,0,0,0 (5 clks); level_valid held with hold
//    full -> ready=0, held word sent once.

Source files
------------

// File: rtl/gas_level_serializer.sv
// -----------------------------------------------------------------------------
// gas_level_serializer
//
// Transmit end of the gas-sensor one-wire link. A 3-bit gas-level code taken
// over a valid/ready handshake is sent on 'dout' as a framed bit stream:
//     START(1)  D2  D1  D0  [PARITY = ~^level]  STOP(0)
// Each bit is held for BIT_CYCLES clocks. A one-entry hold register lets the
// source queue the next code while a frame is on the line, so consecutive
// frames follow each other with no idle clock.
//
// Parameters
//   BIT_CYCLES  clock cycles per transmitted bit (>= 1)
//   PARITY_EN   1: odd-parity bit after the data bits, 0: no parity bit
//
// Ports
//   clk          rising-edge clock
//   arst         asynchronous reset, active low
//   level        gas-level code to send
//   level_valid  source offers 'level' this cycle
//   level_ready  block accepts 'level' this cycle (hold empty, not in reset)
//   dout         registered serial line, idles at 0
//   busy         a frame is on the line
//   frame_done   one-cycle pulse during the last clock of each STOP bit
// -----------------------------------------------------------------------------
module gas_level_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [2:0] level,
    input  logic       level_valid,
    output logic       level_ready,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Odd parity over the 3-bit code: the frame carries ~^level.
    function automatic logic odd_parity(input logic [2:0] d);
        return ~(^d);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [2:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             dout_q, dout_d;
    logic             frame_done_q, frame_done_d;

    logic             xfer_s;
    logic             cnt_wrap_s;
    logic             load_direct_s;

    // Ready only reflects the hold register once reset has been released.
    assign level_ready = arst & ~hold_full_q;
    assign xfer_s      = level_valid & level_ready;
    assign cnt_wrap_s  = (cnt_q == CNT_LAST);

    assign dout        = dout_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_q;

    // Next-state, shifter, hold register and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        load_direct_s = 1'b0;
        dout_d        = 1'b0;
        frame_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer_s) begin
                    shift_d       = level;
                    par_d         = odd_parity(level);
                    cnt_d         = '0;
                    state_d       = S_START;
                    load_direct_s = 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            S_START: begin
                if (cnt_wrap_s) begin
                    cnt_d   = '0;
                    idx_d   = 2'd2;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_wrap_s) begin
                    cnt_d = '0;
                    if (idx_q == 2'd0) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_wrap_s) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_wrap_s) begin
                    cnt_d = '0;
                    // A queued word always wins; ready is low while the hold
                    // is full, so a same-cycle transfer cannot collide with it.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        par_d       = odd_parity(hold_q);
                        hold_full_d = 1'b0;
                        state_d     = S_START;
                    end else if (xfer_s) begin
                        shift_d       = level;
                        par_d         = odd_parity(level);
                        state_d       = S_START;
                        load_direct_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                idx_d       = 2'd0;
                hold_full_d = 1'b0;
            end
        endcase

        // Any accepted word that did not go straight to the shifter is queued.
        if (xfer_s && !load_direct_s) begin
            hold_d      = level;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_d;
        end

        // The line value is registered, so it is derived from the next state.
        case (state_d)
            S_IDLE:   dout_d = 1'b0;
            S_START:  dout_d = 1'b1;
            S_DATA:   dout_d = shift_d[idx_d];
            S_PARITY: dout_d = par_d;
            S_STOP:   dout_d = 1'b0;
            default:  dout_d = 1'b0;
        endcase

        if ((state_d == S_STOP) && (cnt_d == CNT_LAST)) begin
            frame_done_d = 1'b1;
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shift_q      <= 3'd0;
            par_q        <= 1'b0;
            hold_q       <= 3'd0;
            hold_full_q  <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_gas_level_serializer.sv
// -----------------------------------------------------------------------------
// tb_gas_level_serializer
//
// Directed bench for gas_level_serializer. Three instances cover the
// parameter corners: A (BIT_CYCLES=1, parity), B (BIT_CYCLES=4, parity),
// C (BIT_CYCLES=1, no parity). Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_gas_level_serializer;

    typedef struct {
        logic [2:0] lvl;
        logic [5:0] bits;   // expected line bits, first transmitted in [5]
    } vec_t;

    logic       clk_s = 1'b0;
    logic       arst_s;

    logic [2:0] lvl_a, lvl_b, lvl_c;
    logic       vld_a, vld_b, vld_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       dout_a, dout_b, dout_c;
    logic       busy_a, busy_b, busy_c;
    logic       fd_a, fd_b, fd_c;

    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk_s = ~clk_s;

    gas_level_serializer #(.BIT_CYCLES(1), .PARITY_EN(1'b1)) dut_a (
        .clk(clk_s), .arst(arst_s), .level(lvl_a), .level_valid(vld_a),
        .level_ready(rdy_a), .dout(dout_a), .busy(busy_a), .frame_done(fd_a)
    );

    gas_level_serializer #(.BIT_CYCLES(4), .PARITY_EN(1'b1)) dut_b (
        .clk(clk_s), .arst(arst_s), .level(lvl_b), .level_valid(vld_b),
        .level_ready(rdy_b), .dout(dout_b), .busy(busy_b), .frame_done(fd_b)
    );

    gas_level_serializer #(.BIT_CYCLES(1), .PARITY_EN(1'b0)) dut_c (
        .clk(clk_s), .arst(arst_s), .level(lvl_c), .level_valid(vld_c),
        .level_ready(rdy_c), .dout(dout_c), .busy(busy_c), .frame_done(fd_c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Main stimulus and checking sequence.
    initial begin
        vec_t       tbl [5];
        logic [11:0] seq2;
        logic [9:0]  seq_c;
        logic [5:0]  bits_b;
        int          fd_count;

        tbl[0] = '{lvl: 3'b101, bits: 6'b110110};
        tbl[1] = '{lvl: 3'b111, bits: 6'b111100};
        tbl[2] = '{lvl: 3'b000, bits: 6'b100010};
        tbl[3] = '{lvl: 3'b110, bits: 6'b111010};
        tbl[4] = '{lvl: 3'b011, bits: 6'b101110};

        arst_s = 1'b0;
        lvl_a = 3'd0; lvl_b = 3'd0; lvl_c = 3'd0;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk_s);
        chk("rst_dout_a",  {31'd0, dout_a}, 32'd0);
        chk("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        chk("rst_fd_a",    {31'd0, fd_a},   32'd0);
        chk("rst_ready_a", {31'd0, rdy_a},  32'd0);
        chk("rst_ready_b", {31'd0, rdy_b},  32'd0);
        chk("rst_ready_c", {31'd0, rdy_c},  32'd0);
        arst_s = 1'b1;
        #1;
        chk("rel_ready_a", {31'd0, rdy_a}, 32'd1);
        chk("rel_ready_b", {31'd0, rdy_b}, 32'd1);
        chk("rel_ready_c", {31'd0, rdy_c}, 32'd1);

        // ---- single frames from IDLE, table driven ----
        for (int v = 0; v < 5; v++) begin
            @(negedge clk_s);
            lvl_a = tbl[v].lvl;
            vld_a = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_s);
                vld_a = 1'b0;
                chk($sformatf("vec%0d_dout%0d", v, k), {31'd0, dout_a}, {31'd0, tbl[v].bits[5-k]});
                chk($sformatf("vec%0d_fd%0d", v, k), {31'd0, fd_a}, (k == 5) ? 32'd1 : 32'd0);
                chk($sformatf("vec%0d_busy%0d", v, k), {31'd0, busy_a}, 32'd1);
            end
            @(negedge clk_s);
            chk($sformatf("vec%0d_idle_busy", v), {31'd0, busy_a}, 32'd0);
            chk($sformatf("vec%0d_idle_dout", v), {31'd0, dout_a}, 32'd0);
            chk($sformatf("vec%0d_idle_fd", v), {31'd0, fd_a}, 32'd0);
        end

        // ---- queued word via hold register: 010 then 110, contiguous ----
        seq2 = 12'b101000_111010;
        @(negedge clk_s);
        lvl_a = 3'b010;
        vld_a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_s);
            if (k == 0) begin
                chk("hold_ready_c0", {31'd0, rdy_a}, 32'd1);
                lvl_a = 3'b110;
            end else if (k == 1) begin
                vld_a = 1'b0;
                chk("hold_ready_c1", {31'd0, rdy_a}, 32'd0);
            end else if (k == 6) begin
                chk("hold_ready_c6", {31'd0, rdy_a}, 32'd1);
            end
            chk($sformatf("hold_dout%0d", k), {31'd0, dout_a}, {31'd0, seq2[11-k]});
            chk($sformatf("hold_fd%0d", k), {31'd0, fd_a}, ((k == 5) || (k == 11)) ? 32'd1 : 32'd0);
            chk($sformatf("hold_busy%0d", k), {31'd0, busy_a}, 32'd1);
        end
        @(negedge clk_s);
        chk("hold_end_busy", {31'd0, busy_a}, 32'd0);

        // ---- transfer in the STOP cycle with hold empty: straight to shifter ----
        seq2 = 12'b110110_100010;
        @(negedge clk_s);
        lvl_a = 3'b101;
        vld_a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_s);
            if (k == 0) begin
                vld_a = 1'b0;
            end else if (k == 5) begin
                lvl_a = 3'b000;
                vld_a = 1'b1;
            end else if (k == 6) begin
                vld_a = 1'b0;
                chk("b2b_ready_c6", {31'd0, rdy_a}, 32'd1);
            end
            chk($sformatf("b2b_dout%0d", k), {31'd0, dout_a}, {31'd0, seq2[11-k]});
            chk($sformatf("b2b_busy%0d", k), {31'd0, busy_a}, 32'd1);
        end
        @(negedge clk_s);
        chk("b2b_end_busy", {31'd0, busy_a}, 32'd0);

        // ---- BIT_CYCLES=4, code 001: 24-clock frame, one frame_done ----
        bits_b = 6'b100100;
        fd_count = 0;
        @(negedge clk_s);
        lvl_b = 3'b001;
        vld_b = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_s);
            vld_b = 1'b0;
            chk($sformatf("bc4_dout%0d", k), {31'd0, dout_b}, {31'd0, bits_b[5 - (k / 4)]});
            chk($sformatf("bc4_busy%0d", k), {31'd0, busy_b}, 32'd1);
            if (fd_b) begin
                fd_count++;
                chk("bc4_fd_pos", k, 32'd23);
            end
        end
        repeat (4) begin
            @(negedge clk_s);
            if (fd_b) fd_count++;
        end
        chk("bc4_fd_count", fd_count, 32'd1);
        chk("bc4_end_busy", {31'd0, busy_b}, 32'd0);
        chk("bc4_end_dout", {31'd0, dout_b}, 32'd0);

        // ---- reset during D1 of 011 with the hold loaded ----
        @(negedge clk_s);
        lvl_a = 3'b011;
        vld_a = 1'b1;
        @(negedge clk_s);                   // START
        lvl_a = 3'b101;                     // queued into hold at next edge
        @(negedge clk_s);                   // D2
        vld_a = 1'b0;
        chk("abort_hold_ready", {31'd0, rdy_a}, 32'd0);
        @(negedge clk_s);                   // D1
        chk("abort_d1_dout", {31'd0, dout_a}, 32'd1);
        arst_s = 1'b0;
        #1;
        chk("abort_dout", {31'd0, dout_a}, 32'd0);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_fd",   {31'd0, fd_a},   32'd0);
        @(negedge clk_s);
        arst_s = 1'b1;
        #1;
        chk("abort_rel_ready", {31'd0, rdy_a}, 32'd1);
        fd_count = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_s);
            chk($sformatf("abort_idle_dout%0d", k), {31'd0, dout_a}, 32'd0);
            chk($sformatf("abort_idle_busy%0d", k), {31'd0, busy_a}, 32'd0);
            if (fd_a) fd_count++;
        end
        chk("abort_fd_count", fd_count, 32'd0);

        // ---- no parity: 100 then held 011, valid kept high while hold full ----
        seq_c = 10'b11000_10110;
        fd_count = 0;
        @(negedge clk_s);
        lvl_c = 3'b100;
        vld_c = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_s);
            if (k == 0) begin
                lvl_c = 3'b011;
            end else if (k >= 1 && k <= 4) begin
                chk($sformatf("np_ready%0d", k), {31'd0, rdy_c}, 32'd0);
                lvl_c = 3'b111;             // must not overwrite the held word
            end else if (k == 5) begin
                vld_c = 1'b0;
            end
            chk($sformatf("np_dout%0d", k), {31'd0, dout_c}, {31'd0, seq_c[9-k]});
            if (fd_c) fd_count++;
        end
        chk("np_fd_count", fd_count, 32'd2);
        repeat (3) @(negedge clk_s);
        chk("np_end_busy", {31'd0, busy_c}, 32'd0);
        chk("np_end_dout", {31'd0, dout_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
